// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   state_t     - responder FSM states (IDLE, BUSY, RESP)
//   DW          - data/address width (64)
//   ADDR_LSB    - byte-offset bits below the doubleword index (3)
//   access_err  - alignment + range check for a byte address
// Optional feature macro: DMEM_STRB_EN (byte strobes, see dmem_if / dmem_array).
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DW       = 64;
  localparam int ADDR_LSB = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // An access is rejected when it is not doubleword aligned or when its
  // doubleword index falls outside the storage.
  function automatic logic access_err(input logic [DW-1:0] addr,
                                      input int unsigned  depth);
    logic [DW-1:0] idx;
    idx = addr >> ADDR_LSB;
    return (addr[ADDR_LSB-1:0] != '0) || (idx >= 64'(depth));
  endfunction

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// MEM-stage load/store bus between the core (master) and dmem_responder
// (slave).
//   req_valid/req_ready  request handshake
//   req_write            1 = store, 0 = load
//   req_addr             byte address (8-byte aligned)
//   req_wdata            store data
//   req_strb             byte enables (only with DMEM_STRB_EN defined)
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            load data (0 for stores and errors)
//   rsp_err              misaligned or out-of-range access
// -----------------------------------------------------------------------------
interface dmem_if;
  import dmem_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
`ifdef DMEM_STRB_EN
  logic [7:0]    req_strb;
`endif
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
`ifdef DMEM_STRB_EN
    output req_strb,
`endif
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
`ifdef DMEM_STRB_EN
    input  req_strb,
`endif
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x 64-bit storage with synchronous active-low clear, one byte-masked
// write port, one asynchronous read port and live taps on words 0..4.
//   i_clk, i_reset      clock, synchronous active-low clear of all words
//   i_we, i_widx        write enable and word index
//   i_wdata, i_wstrb    write data and byte enables (all ones for full writes)
//   i_ridx, o_rdata     async read port (reads 0 for an index past DEPTH)
//   o_index0..o_index4  current contents of words 0..4
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_widx,
  input  logic [DW-1:0] i_wdata,
  input  logic [7:0]    i_wstrb,
  input  logic [AW-1:0] i_ridx,
  output logic [DW-1:0] o_rdata,
  output logic [DW-1:0] o_index0,
  output logic [DW-1:0] o_index1,
  output logic [DW-1:0] o_index2,
  output logic [DW-1:0] o_index3,
  output logic [DW-1:0] o_index4
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic          w_wr_ok;
  logic          w_rd_ok;

  // Non-power-of-two depths leave index codes with no word behind them.
  assign w_wr_ok = ({1'b0, i_widx} < DEPTH_V);
  assign w_rd_ok = ({1'b0, i_ridx} < DEPTH_V);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we && w_wr_ok) begin
      for (int b = 0; b < 8; b++) begin
        if (i_wstrb[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata  = w_rd_ok ? r_mem[i_ridx] : '0;
  assign o_index0 = r_mem[0];
  assign o_index1 = r_mem[1];
  assign o_index2 = r_mem[2];
  assign o_index3 = r_mem[3];
  assign o_index4 = r_mem[4];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Target end of the MEM-stage load/store bus. Accepts one doubleword request,
// holds it for LATENCY cycles, performs the access and returns a response.
//   i_clk               single clock, rising edge
//   i_reset             synchronous, active-low (0 = reset)
//   io_bus              dmem_if slave modport (request + response handshakes)
//   o_index0..o_index4  live contents of doublewords 0..4
// Parameters: DEPTH (5..1024 words), LATENCY (1..15 cycles).
// Optional feature macro: DMEM_STRB_EN enables req_strb byte-masked stores;
// without it every store writes all 8 bytes.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  dmem_if.slave         io_bus,
  output logic [DW-1:0] o_index0,
  output logic [DW-1:0] o_index1,
  output logic [DW-1:0] o_index2,
  output logic [DW-1:0] o_index3,
  output logic [DW-1:0] o_index4
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [7:0]    r_strb;
  logic [DW-1:0] r_rdata;
  logic          r_err;

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_in_strb_sel;
  logic [7:0]    w_in_strb;
  logic          w_t_write;
  logic [DW-1:0] w_t_addr;
  logic [DW-1:0] w_t_wdata;
  logic [7:0]    w_t_strb;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic          w_we;
  logic [DW-1:0] w_rd_data;

  always_comb begin
`ifdef DMEM_STRB_EN
    w_in_strb = io_bus.req_strb;
`else
    w_in_strb = 8'hFF;
`endif
  end

  assign w_accept      = io_bus.req_valid && (r_state == IDLE);
  assign w_enter_resp  = (r_state != RESP) && (w_next == RESP);
  assign w_in_strb_sel = (r_state == IDLE);

  // With LATENCY==1 the access happens on the accept edge itself, before the
  // request latch is loaded, so the live bus fields are used in IDLE.
  always_comb begin
    w_t_write = r_write;
    w_t_addr  = r_addr;
    w_t_wdata = r_wdata;
    w_t_strb  = r_strb;
    if (w_in_strb_sel) begin
      w_t_write = io_bus.req_write;
      w_t_addr  = io_bus.req_addr;
      w_t_wdata = io_bus.req_wdata;
      w_t_strb  = w_in_strb;
    end
  end

  assign w_err = access_err(w_t_addr, DEPTH);
  assign w_idx = w_t_addr[AW+ADDR_LSB-1:ADDR_LSB];
  assign w_we  = w_enter_resp && w_t_write && !w_err;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (io_bus.req_valid) w_next = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (r_cnt == 4'd0)    w_next = RESP;
      RESP:    if (io_bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state
  always_comb begin
    io_bus.req_ready = (r_state == IDLE);
    io_bus.rsp_valid = (r_state == RESP);
    io_bus.rsp_rdata = r_rdata;
    io_bus.rsp_err   = r_err;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset)                          r_cnt <= 4'd0;
    else if (w_accept)                     r_cnt <= CNT_INIT;
    else if (r_state == BUSY && r_cnt != 0) r_cnt <= r_cnt - 4'd1;
  end

  // Request latch: bus changes after the accept edge cannot reach the access.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_write <= io_bus.req_write;
      r_addr  <= io_bus.req_addr;
      r_wdata <= io_bus.req_wdata;
      r_strb  <= w_in_strb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= (!w_t_write && !w_err) ? w_rd_data : '0;
      r_err   <= w_err;
    end else if (r_state == RESP && io_bus.rsp_ready) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_we     (w_we),
    .i_widx   (w_idx),
    .i_wdata  (w_t_wdata),
    .i_wstrb  (w_t_strb),
    .i_ridx   (w_idx),
    .o_rdata  (w_rd_data),
    .o_index0 (o_index0),
    .o_index1 (o_index1),
    .o_index2 (o_index2),
    .o_index3 (o_index3),
    .o_index4 (o_index4)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Bench for dmem_responder: a LATENCY=2 instance checked every cycle against a
// deadline-based behavioural model, plus a LATENCY=4 instance for the
// reset-while-busy scenario. Inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 32;
  localparam int LAT   = 2;
  localparam int LAT4  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus();
  dmem_if bus4();

  logic [63:0] t_idx0, t_idx1, t_idx2, t_idx3, t_idx4;
  logic [63:0] u_idx0, u_idx1, u_idx2, u_idx3, u_idx4;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .io_bus(bus),
    .o_index0(t_idx0), .o_index1(t_idx1), .o_index2(t_idx2),
    .o_index3(t_idx3), .o_index4(t_idx4)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT4)) u_dut4 (
    .i_clk(clk), .i_reset(rst_n), .io_bus(bus4),
    .o_index0(u_idx0), .o_index1(u_idx1), .o_index2(u_idx2),
    .o_index3(u_idx3), .o_index4(u_idx4)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model of the LATENCY=2 instance -------------
  // A transaction accepted at the edge ending cycle C responds from cycle
  // C+LAT; the access is applied at that moment.
  logic [63:0] m_mem [DEPTH];
  bit          m_busy = 0, m_resp = 0, m_err = 0, m_wr = 0;
  int          m_due = 0, m_i = 0;
  logic [63:0] m_addr = '0, m_wd = '0, m_rdata = '0;
  logic [7:0]  m_strb = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_busy = 0; m_resp = 0; m_err = 0; m_rdata = '0;
    end else begin
      if (m_resp && bus.rsp_ready) begin
        m_resp = 0; m_err = 0; m_rdata = '0;
      end else if (!m_busy && !m_resp && bus.req_valid) begin
        m_busy = 1;
        m_wr   = bus.req_write;
        m_addr = bus.req_addr;
        m_wd   = bus.req_wdata;
`ifdef DMEM_STRB_EN
        m_strb = bus.req_strb;
`else
        m_strb = 8'hFF;
`endif
        m_due  = cyc - 1 + LAT;
      end
      if (m_busy && cyc == m_due) begin
        m_busy  = 0;
        m_resp  = 1;
        m_err   = (m_addr[2:0] != 3'd0) || ((m_addr >> 3) >= 64'(DEPTH));
        m_rdata = '0;
        if (!m_err) begin
          m_i = int'(m_addr >> 3);
          if (m_wr) begin
            for (int b = 0; b < 8; b++)
              if (m_strb[b]) m_mem[m_i][8*b +: 8] = m_wd[8*b +: 8];
          end else begin
            m_rdata = m_mem[m_i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("cmp_req_ready", 64'(bus.req_ready), 64'(!m_busy && !m_resp));
      chk("cmp_rsp_valid", 64'(bus.rsp_valid), 64'(m_resp));
      chk("cmp_rsp_rdata", bus.rsp_rdata, m_rdata);
      chk("cmp_rsp_err",   64'(bus.rsp_err), 64'(m_err));
      chk("cmp_index0", t_idx0, m_mem[0]);
      chk("cmp_index1", t_idx1, m_mem[1]);
      chk("cmp_index2", t_idx2, m_mem[2]);
      chk("cmp_index3", t_idx3, m_mem[3]);
      chk("cmp_index4", t_idx4, m_mem[4]);
    end
  end

  // ---------------- stimulus helpers (LATENCY=2 instance) --------------------
  task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] s, output int acc);
    int n = 0;
    while (!bus.req_ready && n < 40) begin @(negedge clk); n++; end
    chk("req_timeout", 64'(n < 40), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
`ifdef DMEM_STRB_EN
    bus.req_strb  = s;
`endif
    acc = cyc;
    @(negedge clk);
    // Scramble the bus after acceptance; the transaction must not notice.
    bus.req_valid = 1'b0;
    bus.req_write = ~w;
    bus.req_addr  = 64'h8;
    bus.req_wdata = ~d;
`ifdef DMEM_STRB_EN
    bus.req_strb  = ~s;
`endif
  endtask

  task automatic wait_valid(output int vc);
    int n = 0;
    while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk("rsp_timeout", 64'(n < 40), 64'd1);
    vc = cyc;
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int acc, vc, n;
    logic [63:0] X4, Y4;
    X4 = 64'hA5A5_0000_1234_5678;
    Y4 = 64'h0BAD_F00D_0BAD_F00D;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 0;
    bus4.req_valid = 0; bus4.req_write = 0; bus4.req_addr = '0; bus4.req_wdata = '0;
    bus4.rsp_ready = 0;
`ifdef DMEM_STRB_EN
    bus.req_strb = 8'hFF; bus4.req_strb = 8'hFF;
`endif

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("rst_index2", t_idx2, 64'd0);
    rst_n = 1'b1;
    while (cyc < 5) @(negedge clk);

    // Store 0x10 accepted in cycle 5 -> response in cycle 7
    do_req(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, acc);
    chk("store_acc_cycle", 64'(acc), 64'd5);
    wait_valid(vc);
    chk("store_rsp_cycle", 64'(vc), 64'd7);
    chk("store_err", 64'(bus.rsp_err), 64'd0);
    chk("store_rdata", bus.rsp_rdata, 64'd0);
    chk("store_index2", t_idx2, 64'hDEADBEEF_CAFEF00D);
    finish_rsp();

    // Load back with a 5-cycle response hold and a blocked request meanwhile
    do_req(1'b0, 64'h10, 64'h0, 8'hFF, acc);
    wait_valid(vc);
    chk("load_rsp_cycle", 64'(vc), 64'(acc + LAT));
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 64'h0;
    bus.req_wdata = 64'h7777_7777_7777_7777;
    for (int i = 0; i < 5; i++) begin
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_rdata", bus.rsp_rdata, 64'hDEADBEEF_CAFEF00D);
      if (i < 4) @(negedge clk);
    end
    bus.req_valid = 1'b0;
    finish_rsp();
    chk("turnaround_ready", 64'(bus.req_ready), 64'd1);
    chk("hold_no_store_index0", t_idx0, 64'd0);

    // Misaligned and out-of-range accesses
    do_req(1'b1, 64'h0C, 64'h5555_5555_5555_5555, 8'hFF, acc);
    wait_valid(vc);
    chk("misal_err", 64'(bus.rsp_err), 64'd1);
    chk("misal_rdata", bus.rsp_rdata, 64'd0);
    chk("misal_index1", t_idx1, 64'd0);
    chk("misal_index2", t_idx2, 64'hDEADBEEF_CAFEF00D);
    finish_rsp();
    do_req(1'b1, 64'(DEPTH * 8), 64'h6666_6666_6666_6666, 8'hFF, acc);
    wait_valid(vc);
    chk("oor_store_err", 64'(bus.rsp_err), 64'd1);
    chk("oor_store_index0", t_idx0, 64'd0);
    finish_rsp();
    do_req(1'b0, 64'(DEPTH * 8), 64'h0, 8'hFF, acc);
    wait_valid(vc);
    chk("oor_load_err", 64'(bus.rsp_err), 64'd1);
    chk("oor_load_rdata", bus.rsp_rdata, 64'd0);
    finish_rsp();

    // Last valid word round trip
    do_req(1'b1, 64'(DEPTH * 8 - 8), 64'h0123_4567_89AB_CDEF, 8'hFF, acc);
    wait_valid(vc);
    chk("last_store_err", 64'(bus.rsp_err), 64'd0);
    finish_rsp();
    do_req(1'b0, 64'(DEPTH * 8 - 8), 64'h0, 8'hFF, acc);
    wait_valid(vc);
    chk("last_load_rdata", bus.rsp_rdata, 64'h0123_4567_89AB_CDEF);
    chk("last_load_err", 64'(bus.rsp_err), 64'd0);
    finish_rsp();

    // Byte strobes (full-word store in the default build)
`ifdef DMEM_STRB_EN
    do_req(1'b1, 64'h08, 64'h1111_1111_1111_1111, 8'hFF, acc);
    wait_valid(vc); finish_rsp();
    chk("strb_base_index1", t_idx1, 64'h1111_1111_1111_1111);
    do_req(1'b1, 64'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, acc);
    wait_valid(vc);
    chk("strb_index1", t_idx1, 64'h1111_1111_FFFF_FFFF);
    finish_rsp();
    do_req(1'b1, 64'h08, 64'h2222_2222_2222_2222, 8'h00, acc);
    wait_valid(vc);
    chk("strb0_err", 64'(bus.rsp_err), 64'd0);
    chk("strb0_index1", t_idx1, 64'h1111_1111_FFFF_FFFF);
    finish_rsp();
`else
    do_req(1'b1, 64'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, acc);
    wait_valid(vc);
    chk("full_index1", t_idx1, 64'hFFFF_FFFF_FFFF_FFFF);
    finish_rsp();
`endif

    // LATENCY=4 instance: commit one store, then reset mid-BUSY
    @(negedge clk);
    bus4.req_valid = 1'b1; bus4.req_write = 1'b1; bus4.req_addr = 64'h18; bus4.req_wdata = X4;
    @(negedge clk);
    bus4.req_valid = 1'b0;
    n = 0;
    while (!bus4.rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk("l4_rsp_timeout", 64'(n < 40), 64'd1);
    chk("l4_index3", u_idx3, X4);
    bus4.rsp_ready = 1'b1;
    @(negedge clk);
    bus4.rsp_ready = 1'b0;
    chk("l4_ready", 64'(bus4.req_ready), 64'd1);
    bus4.req_valid = 1'b1; bus4.req_addr = 64'h20; bus4.req_wdata = Y4;
    @(negedge clk);
    bus4.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("l4_post_rst_ready", 64'(bus4.req_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("l4_no_rsp", 64'(bus4.rsp_valid), 64'd0);
      chk("l4_index3_zero", u_idx3, 64'd0);
      chk("l4_index4_zero", u_idx4, 64'd0);
      @(negedge clk);
    end
    chk("main_index2_zero", t_idx2, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: the target end of the MEM-stage load/store interface. Accepts one doubleword load or store request via a valid/ready handshake and holds it for a configurable access latency. It then returns a response (read data or store acknowledge) via a second valid/ready handshake. It exposes the first five doublewords as debug taps so the bench can watch stores land, and it flags misaligned or out-of-range accesses instead of corrupting storage.

## Interface
- DEPTH, 32, number of 64-bit doublewords stored; valid range 5..1024.
- LATENCY, 2, cycles from request acceptance to rsp_valid; valid range 1..15.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on clk rising edge; 0 = reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address; must be 8-byte aligned.
- req_wdata  in  64  store data.
- req_strb  in  8  byte write enables; present only with DMEM_STRB_EN.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  64  load data; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or out of range.
- index0..index4  out  64 each  live contents of doublewords 0..4.

## Operation
- FSM states: IDLE, BUSY, RESP.
- Reset, while reset==0 at an edge:
  - state goes to IDLE and all storage is zeroed.
  - req_ready is 1; rsp_valid, rsp_err and rsp_rdata are 0; index0..4 are 0.
- Accept: the req_valid && req_ready edge latches write, addr, wdata (and strb) into internal registers.
  - After the accept edge, input changes have no effect on the transaction.
- IDLE -> RESP on accept if LATENCY==1.
- IDLE -> BUSY on accept if LATENCY>1. The down-counter loads LATENCY-2.
- BUSY: the counter decrements each cycle. When it is 0, the next edge moves to RESP.
- Access is performed on the edge entering RESP:
  - Index = addr[63:3]. Error = (addr[2:0]!=0) or (index >= DEPTH).
  - Load, no error: rsp_rdata = mem[index].
  - Store, no error: mem[index] is written; rsp_rdata = 0.
  - Error: storage is untouched, rsp_rdata = 0, rsp_err = 1.
- RESP: rsp_valid=1 and outputs are stable until rsp_valid && rsp_ready. The next state is IDLE and rsp_valid, rsp_err and rsp_rdata clear to 0.
- req_valid outside IDLE is ignored (not accepted, not queued). Only one transaction is ever outstanding.
- index taps reflect storage combinationally; a store is visible on them from the cycle rsp_valid rises.
- Reset mid-BUSY abandons the transaction: no write, no response. Reset in RESP drops the response; the already-committed store remains until the reset zeroes storage.

## Timing
- Accept edge ends cycle C; rsp_valid is high from cycle C+LATENCY.
- Minimum turnaround: a response accepted in cycle R gives req_ready=1 in R+1. Peak throughput is one transaction per LATENCY+1 cycles.
- req_ready and rsp_valid are registered-state decodes, never combinational from inputs.

## Configuration
- DMEM_STRB_EN defined:
  - The req_strb port exists. Store writes only the bytes where strb[i]=1 (byte i = bits 8i+7:8i); other bytes are kept.
  - A store with strb==0 completes with no change and rsp_err=0.
- DMEM_STRB_EN undefined: the port is absent and every store writes all 8 bytes.

## Structure
- Shared package dmem_pkg:
  - state enum {IDLE, BUSY, RESP}.
  - DW=64 and ADDR_LSB=3.
  - Error-check function (alignment + range).
- One sub-module, dmem_array: DEPTH x 64 storage with sync reset-clear, write port (optional byte strobes), async read port and the five index taps. The FSM, counter and request latch stay in dmem_responder.

## Test plan
- Reset, then LATENCY=2: store addr 0x10, data 0xDEADBEEF_CAFEF00D accepted in cycle 5 -> rsp_valid in cycle 7, rsp_err=0, index2=0xDEADBEEF_CAFEF00D.
- Load addr 0x10 after that store -> rsp_rdata=0xDEADBEEF_CAFEF00D, LATENCY cycles after accept.
- rsp_ready held low 4 cycles -> rsp_valid and rsp_rdata stable; req_valid with addr 0x0 during the hold is not accepted; req_ready=0 throughout.
- Store to 0x0C (misaligned) and to DEPTH*8 (out of range) -> rsp_err=1, rsp_rdata=0, index0..4 unchanged.
- Reset asserted two cycles after accepting a store with LATENCY=4 -> no rsp_valid, storage all zero, req_ready=1 the cycle after reset releases.
- DMEM_STRB_EN: word 1 = 0x1111_1111_1111_1111, store 0xFFFF_FFFF_FFFF_FFFF with strb=0x0F to 0x08 -> index1=0x1111_1111_FFFF_FFFF.
